scan_seq_ctrl: RTL and testbench
================================

Name: scan_seq_ctrl

Overview:
- On-chip scan-test sequencer sitting between the test pads (TEN, SDI, SDO) and the SoC scan chain/scan-enable inputs.
- When test mode is enabled and a run is started, drives scan enable and serial data through a fixed sequence: chain load, capture, overlapped unload/load for each pattern, then a final unload.
- Frees the tester from generating SE timing; the tester only streams SDI and samples SDO.

Parameters:
- CHAIN_LEN, 64, scan chain length in flops; legal range 2..1024.
- CNT_W, 11, shift counter width; must satisfy 2^CNT_W > CHAIN_LEN.
- CAP_CYC, 1, capture cycles per pattern with SE low; legal range 1..4.
- PAT_W, 16, width of the pattern count and pattern counter.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RSTn  in  1  asynchronous active-low reset.
- TEN  in  1  test enable from the pad; asynchronous; 2-flop synchronised internally to TEN_s.
- START  in  1  one-cycle run request.
- NPAT  in  PAT_W  number of patterns; sampled with START.
- SDI_IN  in  1  serial data from the SDI pad.
- CHAIN_OUT  in  1  scan chain tail.
- SE_OUT  out  1  scan enable to the SoC; registered.
- CHAIN_IN  out  1  scan chain head; equals SDI_IN while SE_OUT=1, else 0 (combinational).
- SDO_OUT  out  1  registered CHAIN_OUT toward the SDO pad.
- BUSY  out  1  high from the first SHIFT cycle through the last UNLOAD cycle.
- DONE  out  1  one-cycle pulse at normal completion.
- ERR  out  1  sticky abort flag.
- PAT_CNT  out  PAT_W  captures completed in the current or last run.

Behaviour:
- Reset: all outputs 0 (SE_OUT, SDO_OUT, BUSY, DONE, ERR, PAT_CNT). State is IDLE, counters and TEN_s are cleared.
- States: IDLE, SHIFT, CAPTURE, UNLOAD, FIN.

IDLE:
- START is accepted only when TEN_s=1.
- On accept: latch NPAT, clear PAT_CNT and ERR, shift counter <= 0.
  - NPAT!=0: go to SHIFT.
  - NPAT==0: go to FIN with no shifting.

SHIFT (SE_OUT=1):
- Shift counter increments each cycle.
- After CHAIN_LEN cycles: counter <= 0, go to CAPTURE.

CAPTURE (SE_OUT=0):
- Lasts CAP_CYC cycles.
- PAT_CNT increments on the last capture cycle.
- Then, with counter <= 0:
  - PAT_CNT (updated) < latched NPAT: go to SHIFT, which overlaps unload of pattern k with load of k+1.
  - Otherwise: go to UNLOAD.

UNLOAD (SE_OUT=1):
- Lasts CHAIN_LEN cycles, then go to FIN.

FIN:
- DONE=1 for exactly one cycle, then go to IDLE.

Timing:
- SE_OUT is registered from the next-state decode, so SE_OUT is 1 in exactly the cycles the FSM is in SHIFT or UNLOAD.
- START sampled at edge k puts the first SHIFT cycle at k+1.
- Total BUSY cycles for NPAT=N≥1: (N+1)*CHAIN_LEN + N*CAP_CYC. DONE follows in the next cycle.

SDO_OUT:
- Loads CHAIN_OUT on every cycle where SE_OUT=1.
- Holds its value otherwise.

START rules:
- START while not IDLE is ignored.
- START with TEN_s=0 is ignored.

Abort:
- TEN_s falling while not IDLE forces IDLE on the next edge.
- In that cycle SE_OUT, BUSY and DONE go to 0 and ERR goes to 1.
- PAT_CNT holds its value.
- ERR stays set until the next accepted START.

Counters and reset:
- The pattern counter saturates at 2^PAT_W-1. It cannot exceed NPAT in normal operation.
- RSTn assertion at any point returns all outputs to reset values immediately.

Test Plan:
1. Bench with CHAIN_LEN=8, CAP_CYC=1. Assert RSTn low mid-SHIFT -> SE_OUT, BUSY, ERR, PAT_CNT read 0 asynchronously. After release, state is IDLE.
2. TEN=1, START with NPAT=1 -> SE_OUT high 8, low 1, high 8 cycles. BUSY high 17 cycles; DONE pulses at cycle 18; PAT_CNT=1; ERR=0.
3. NPAT=3 -> BUSY 35 cycles, exactly three single-cycle SE_OUT lows spaced 9 cycles apart, PAT_CNT=3, one DONE pulse.
4. Loop CHAIN_IN to CHAIN_OUT through an 8-flop bench shift register. Drive SDI_IN=1,0,1,1,0,0,1,0 in the first SHIFT, NPAT=1, with the model holding its state across capture. SDO_OUT during UNLOAD reproduces 1,0,1,1,0,0,1,0, delayed by one cycle.
5. Drop TEN at SHIFT cycle 4 of pattern 2 (NPAT=3) -> within 3 cycles SE_OUT=0, BUSY=0, ERR=1, PAT_CNT=1, no DONE. The next START clears ERR.
6. NPAT=0 -> DONE in the second cycle after START, SE_OUT never rises. A START pulsed during BUSY of an NPAT=2 run is ignored: total BUSY stays 26 cycles.

Source files
------------

// File: rtl/scan_seq_ctrl.sv
// Scan-test sequencer: drives scan enable and chain data through load, capture,
// overlapped unload/load per pattern and a final unload, with abort on loss of test mode.
module scan_seq_ctrl #(
   parameter int CHAIN_LEN = 64,
   parameter int CNT_W     = 11,
   parameter int CAP_CYC   = 1,
   parameter int PAT_W     = 16
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             TEN,
   input  logic             START,
   input  logic [PAT_W-1:0] NPAT,
   input  logic             SDI_IN,
   input  logic             CHAIN_OUT,
   output logic             SE_OUT,
   output logic             CHAIN_IN,
   output logic             SDO_OUT,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR,
   output logic [PAT_W-1:0] PAT_CNT
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SHIFT   = 3'd1;
   localparam logic [2:0] ST_CAPTURE = 3'd2;
   localparam logic [2:0] ST_UNLOAD  = 3'd3;
   localparam logic [2:0] ST_FIN     = 3'd4;

   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
   localparam logic [1:0]       LAST_CAP   = 2'(CAP_CYC - 1);
   localparam logic [PAT_W-1:0] PAT_MAX    = {PAT_W{1'b1}};

   logic             ten_meta_r, ten_s_r;
   logic [2:0]       state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic [1:0]       cap_r, cap_nxt_s;
   logic [PAT_W-1:0] npat_r, npat_nxt_s;
   logic [PAT_W-1:0] pat_r, pat_nxt_s, pat_inc_s;
   logic             err_r, err_nxt_s;
   logic             se_r, busy_r, done_r, sdo_r;

   assign pat_inc_s = (pat_r == PAT_MAX) ? pat_r : pat_r + PAT_W'(1);

   // Next-state and counter decode; loss of test mode outside IDLE overrides everything
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      cap_nxt_s   = cap_r;
      npat_nxt_s  = npat_r;
      pat_nxt_s   = pat_r;
      err_nxt_s   = err_r;
      if ((state_r != ST_IDLE) && !ten_s_r) begin
         state_nxt_s = ST_IDLE;
         err_nxt_s   = 1'b1;
         cnt_nxt_s   = {CNT_W{1'b0}};
         cap_nxt_s   = 2'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (START && ten_s_r) begin
                  npat_nxt_s  = NPAT;
                  pat_nxt_s   = {PAT_W{1'b0}};
                  err_nxt_s   = 1'b0;
                  cnt_nxt_s   = {CNT_W{1'b0}};
                  cap_nxt_s   = 2'd0;
                  state_nxt_s = (NPAT != {PAT_W{1'b0}}) ? ST_SHIFT : ST_FIN;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_SHIFT: begin
               if (cnt_r == LAST_SHIFT) begin
                  cnt_nxt_s   = {CNT_W{1'b0}};
                  state_nxt_s = ST_CAPTURE;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_W'(1);
               end
            end
            ST_CAPTURE: begin
               if (cap_r == LAST_CAP) begin
                  cap_nxt_s   = 2'd0;
                  cnt_nxt_s   = {CNT_W{1'b0}};
                  pat_nxt_s   = pat_inc_s;
                  // next load overlaps unload of the pattern just captured
                  state_nxt_s = (pat_inc_s < npat_r) ? ST_SHIFT : ST_UNLOAD;
               end else begin
                  cap_nxt_s = cap_r + 2'd1;
               end
            end
            ST_UNLOAD: begin
               if (cnt_r == LAST_SHIFT) begin
                  cnt_nxt_s   = {CNT_W{1'b0}};
                  state_nxt_s = ST_FIN;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_W'(1);
               end
            end
            ST_FIN: begin
               state_nxt_s = ST_IDLE;
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // Test-enable synchroniser
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         ten_meta_r <= 1'b0;
         ten_s_r    <= 1'b0;
      end else begin
         ten_meta_r <= TEN;
         ten_s_r    <= ten_meta_r;
      end
   end

   // FSM state, counters and outputs registered from the next-state decode
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         cap_r   <= 2'd0;
         npat_r  <= {PAT_W{1'b0}};
         pat_r   <= {PAT_W{1'b0}};
         err_r   <= 1'b0;
         se_r    <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         cap_r   <= cap_nxt_s;
         npat_r  <= npat_nxt_s;
         pat_r   <= pat_nxt_s;
         err_r   <= err_nxt_s;
         se_r    <= (state_nxt_s == ST_SHIFT) || (state_nxt_s == ST_UNLOAD);
         busy_r  <= (state_nxt_s == ST_SHIFT) || (state_nxt_s == ST_CAPTURE) ||
                    (state_nxt_s == ST_UNLOAD);
         done_r  <= (state_nxt_s == ST_FIN);
      end
   end

   // Chain tail capture toward SDO, only while shifting
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         sdo_r <= 1'b0;
      end else if (se_r) begin
         sdo_r <= CHAIN_OUT;
      end else begin
         sdo_r <= sdo_r;
      end
   end

   assign SE_OUT   = se_r;
   assign CHAIN_IN = se_r ? SDI_IN : 1'b0;
   assign SDO_OUT  = sdo_r;
   assign BUSY     = busy_r;
   assign DONE     = done_r;
   assign ERR      = err_r;
   assign PAT_CNT  = pat_r;

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed bench for scan_seq_ctrl with an 8-flop chain model looped from CHAIN_IN to CHAIN_OUT.
module tb_scan_seq_ctrl;

   logic        CLK = 1'b0;
   logic        RSTn, TEN, START, SDI_IN;
   logic [15:0] NPAT;
   logic        CHAIN_OUT, SE_OUT, CHAIN_IN, SDO_OUT, BUSY, DONE, ERR;
   logic [15:0] PAT_CNT;

   logic [7:0]  chain_r = 8'd0;
   logic [7:0]  sdi_pat = 8'b10110010;
   logic        se_t   [0:63];
   logic        busy_t [0:63];
   logic        done_t [0:63];
   logic        sdo_t  [0:63];
   logic        err_t  [0:63];
   int          vec_cnt = 0;
   int          err_cnt = 0;

   scan_seq_ctrl #(.CHAIN_LEN(8), .CNT_W(4), .CAP_CYC(1), .PAT_W(16)) dut (
      .CLK(CLK), .RSTn(RSTn), .TEN(TEN), .START(START), .NPAT(NPAT),
      .SDI_IN(SDI_IN), .CHAIN_OUT(CHAIN_OUT), .SE_OUT(SE_OUT), .CHAIN_IN(CHAIN_IN),
      .SDO_OUT(SDO_OUT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .PAT_CNT(PAT_CNT)
   );

   always #5 CLK = ~CLK;

   // Scan chain model: shifts only while scan enable is high
   always @(posedge CLK) begin
      if (SE_OUT) chain_r <= {chain_r[6:0], CHAIN_IN};
   end
   assign CHAIN_OUT = chain_r[7];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge CLK);
   endtask

   // Pulse START, then record one sample per cycle; optional TEN drop and second START
   task automatic run_seq(input logic [15:0] npat, input int ncyc, input int drop_at,
                          input int restart_at);
      @(negedge CLK);
      START = 1'b1;
      NPAT  = npat;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge CLK);
         START     = 1'b0;
         se_t[i]   = SE_OUT;
         busy_t[i] = BUSY;
         done_t[i] = DONE;
         sdo_t[i]  = SDO_OUT;
         err_t[i]  = ERR;
         SDI_IN    = (i < 8) ? sdi_pat[7-i] : 1'b0;
         if (i == drop_at) TEN = 1'b0;
         if (i == restart_at) begin
            START = 1'b1;
            NPAT  = 16'd5;
         end
      end
   endtask

   function automatic int count_ones(input int which, input int n);
      int c = 0;
      for (int i = 0; i < n; i++) begin
         case (which)
            0:       c += int'(se_t[i]);
            1:       c += int'(busy_t[i]);
            default: c += int'(done_t[i]);
         endcase
      end
      return c;
   endfunction

   initial begin
      logic [7:0] sdo_got;
      RSTn = 1'b0; TEN = 1'b0; START = 1'b0; NPAT = 16'd0; SDI_IN = 1'b0;
      #12;
      check_val("rst_se",   32'(SE_OUT),  32'd0);
      check_val("rst_sdo",  32'(SDO_OUT), 32'd0);
      check_val("rst_busy", 32'(BUSY),    32'd0);
      check_val("rst_done", 32'(DONE),    32'd0);
      check_val("rst_err",  32'(ERR),     32'd0);
      check_val("rst_pat",  32'(PAT_CNT), 32'd0);
      @(negedge CLK);
      RSTn = 1'b1;
      TEN  = 1'b1;
      wait_cyc(4);

      // async reset in the middle of a shift
      run_seq(16'd1, 3, -1, -1);
      check_val("pre_rst_se", 32'(SE_OUT), 32'd1);
      #2 RSTn = 1'b0;
      #1;
      check_val("arst_se",   32'(SE_OUT),  32'd0);
      check_val("arst_busy", 32'(BUSY),    32'd0);
      check_val("arst_err",  32'(ERR),     32'd0);
      check_val("arst_pat",  32'(PAT_CNT), 32'd0);
      @(negedge CLK);
      RSTn = 1'b1;
      wait_cyc(3);
      check_val("post_rst_idle", {30'd0, SE_OUT, BUSY}, 32'd0);

      // single pattern with chain loopback
      run_seq(16'd1, 20, -1, -1);
      check_val("p1_busy_cnt", 32'(count_ones(1, 20)), 32'd17);
      check_val("p1_se_cnt",   32'(count_ones(0, 20)), 32'd16);
      check_val("p1_se_edges", {29'd0, se_t[7], se_t[8], se_t[9]}, 32'b101);
      check_val("p1_done_at",  32'(done_t[17]), 32'd1);
      check_val("p1_done_cnt", 32'(count_ones(2, 20)), 32'd1);
      check_val("p1_pat",      32'(PAT_CNT), 32'd1);
      check_val("p1_err",      32'(ERR),     32'd0);
      for (int k = 0; k < 8; k++) sdo_got[7-k] = sdo_t[10+k];
      check_val("p1_sdo_stream", 32'(sdo_got), 32'h000000B2);

      // three patterns
      run_seq(16'd3, 40, -1, -1);
      check_val("p3_busy_cnt", 32'(count_ones(1, 40)), 32'd35);
      check_val("p3_se_cnt",   32'(count_ones(0, 40)), 32'd32);
      check_val("p3_se_lows",  {29'd0, se_t[8], se_t[17], se_t[26]}, 32'd0);
      check_val("p3_done_at",  32'(done_t[35]), 32'd1);
      check_val("p3_done_cnt", 32'(count_ones(2, 40)), 32'd1);
      check_val("p3_pat",      32'(PAT_CNT), 32'd3);

      // TEN dropped at shift cycle 4 of pattern 2
      run_seq(16'd3, 25, 12, -1);
      check_val("ab_se_before", 32'(se_t[14]), 32'd1);
      check_val("ab_se",        32'(se_t[15]), 32'd0);
      check_val("ab_busy",      32'(busy_t[15]), 32'd0);
      check_val("ab_err",       32'(err_t[15]), 32'd1);
      check_val("ab_pat",       32'(PAT_CNT), 32'd1);
      check_val("ab_no_done",   32'(count_ones(2, 25)), 32'd0);
      check_val("ab_err_stick", 32'(ERR), 32'd1);
      TEN = 1'b1;
      wait_cyc(3);
      run_seq(16'd1, 20, -1, -1);
      check_val("ab_err_clr",   32'(err_t[0]), 32'd0);
      check_val("ab_rerun_done", 32'(count_ones(2, 20)), 32'd1);

      // START without test mode is ignored
      TEN = 1'b0;
      wait_cyc(3);
      run_seq(16'd2, 10, -1, -1);
      check_val("noten_busy", 32'(count_ones(1, 10)), 32'd0);
      check_val("noten_done", 32'(count_ones(2, 10)), 32'd0);
      TEN = 1'b1;
      wait_cyc(3);

      // zero patterns
      run_seq(16'd0, 6, -1, -1);
      check_val("np0_done_at",  32'(done_t[0]), 32'd1);
      check_val("np0_done_cnt", 32'(count_ones(2, 6)), 32'd1);
      check_val("np0_se",       32'(count_ones(0, 6)), 32'd0);
      check_val("np0_busy",     32'(count_ones(1, 6)), 32'd0);

      // START during a run is ignored
      run_seq(16'd2, 32, -1, 5);
      check_val("ign_busy_cnt", 32'(count_ones(1, 32)), 32'd26);
      check_val("ign_done_at",  32'(done_t[26]), 32'd1);
      check_val("ign_done_cnt", 32'(count_ones(2, 32)), 32'd1);
      check_val("ign_pat",      32'(PAT_CNT), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
